// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// Stream FIFO controller for a single-port RAM with a registered address.
// One RAM port is shared between pushes and prefetch reads, and reads win.
// A prefetched word is loaded into a one-word output register. The total
// capacity is therefore 2**ADDR_WIDTH + 1 words.
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   wr_valid/wr_ready/wr_data  push side (transfer on wr_valid & wr_ready)
//   rd_valid/rd_ready/rd_data  pop side, with rd_data registered
//   ram_wr_en/ram_addr/ram_w_data/ram_r_data  connection to the RAM
//   level                    words held (RAM + in-flight + output register)
//   full                     RAM region holds DEPTH unread words
//   empty                    level == 0
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  input  logic [DATA_WIDTH-1:0] ram_r_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  rd_issue;
  logic                  push;
  logic                  pop;
  logic                  fetch_vld;

  // Port arbitration. A read is issued only when the output register will be
  // free at the edge that ends the FETCH cycle, so FETCH never finds it full.
  always_comb begin
    fetch_vld  = (state == FETCH);
    rd_issue   = (state == IDLE) && (ram_cnt != '0) && (!rd_valid || rd_ready);
    full       = (ram_cnt == DEPTH_CNT);
    wr_ready   = !full && !rd_issue && rst_n;
    push       = wr_valid && wr_ready;
    pop        = rd_valid && rd_ready;
    ram_wr_en  = push;
    ram_addr   = rd_issue ? rd_ptr : wr_ptr;
    ram_w_data = wr_data;
    level      = ram_cnt + {{ADDR_WIDTH{1'b0}}, fetch_vld} + {{ADDR_WIDTH{1'b0}}, rd_valid};
    empty      = (level == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_issue) state_nxt = FETCH;
      FETCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage boundary: pointer and occupancy bookkeeping at issue/push time.
  // Push and issue never coincide, so ram_cnt moves by at most one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_issue) rd_ptr <= rd_ptr + PTR_ONE;
      if (push)          ram_cnt <= ram_cnt + CNT_ONE;
      else if (rd_issue) ram_cnt <= ram_cnt - CNT_ONE;
    end
  end

  // Stage boundary: FETCH -> output register. A load and a pop never share
  // an edge because rd_valid is low throughout FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (fetch_vld) begin
      rd_valid <= 1'b1;
      rd_data  <= ram_r_data;
    end else if (pop) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural RAM and a queue reference model.
module tb_ram_fifo_ctrl;
  localparam int DW = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_w_data;
  logic [DW-1:0] ram_r_data;
  logic [AW:0]   level;
  logic          full;
  logic          empty;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data), .level(level), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Single-port RAM: registered address, write-through not needed.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] addr_q;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_w_data;
    addr_q <= ram_addr;
  end
  assign ram_r_data = mem[addr_q];

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] model_q[$];
  int n_acc = 0;
  int n_pop = 0;
  int cyc = 0;
  int last_pop = 0;
  int pop_gap = 0;
  logic prev_rd_valid = 1'b0;
  logic prev_popped = 1'b0;
  logic chk_issue = 1'b0;
  logic low_km1 = 1'b0;
  logic low_km2 = 1'b0;
  int phase_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1; applies inputs and waits to mid-cycle.
  task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic rr);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(negedge clk);
  endtask

  // Called mid-cycle; records handshakes into the model, crosses the edge,
  // then compares occupancy against the model.
  task automatic commit();
    logic acc, popd, loaded;
    acc    = wr_valid && wr_ready;
    popd   = rd_valid && rd_ready;
    loaded = rd_valid && (!prev_rd_valid || prev_popped);
    if (chk_issue) begin
      // A RAM read stalls the push port and lands in rd_data two cycles later.
      if (phase_cyc >= 2) check_eq("issue_vs_wr_ready", 32'(loaded), 32'(low_km2));
      low_km2 = low_km1;
      low_km1 = !wr_ready && !full;
      phase_cyc++;
    end
    prev_rd_valid = rd_valid;
    prev_popped   = popd;
    check_eq("ram_w_data", 32'(ram_w_data), 32'(wr_data));
    if (popd) begin
      if (model_q.size() > 0) check_eq("rd_data_order", 32'(rd_data), 32'(model_q.pop_front()));
      else check_eq("pop_with_empty_model", 32'(model_q.size()), 32'd1);
      n_pop++;
      pop_gap  = cyc - last_pop;
      last_pop = cyc;
    end
    if (acc) begin
      model_q.push_back(wr_data);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_eq("level", 32'(level), 32'(model_q.size()));
    check_eq("empty", 32'(empty), 32'(model_q.size() == 0));
    check_eq("level_le_9", 32'(level > 9), 32'd0);
  endtask

  initial begin
    int base_acc, base_pop, d;
    logic a;

    // Reset with a push request pending.
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 4'h3; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push of 0xA into an empty FIFO.
    drive(1'b1, 4'hA, 1'b0);
    check_eq("sp_c0_wr_en", 32'(ram_wr_en), 32'd1);
    check_eq("sp_c0_addr", 32'(ram_addr), 32'd0);
    check_eq("sp_c0_wr_ready", 32'(wr_ready), 32'd1);
    commit();
    drive(1'b0, 4'h0, 1'b0);
    check_eq("sp_c1_wr_en", 32'(ram_wr_en), 32'd0);
    check_eq("sp_c1_addr", 32'(ram_addr), 32'd0);
    check_eq("sp_c1_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("sp_c1_rd_valid", 32'(rd_valid), 32'd0);
    commit();
    drive(1'b0, 4'h0, 1'b0);
    check_eq("sp_c2_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("sp_c2_wr_ready", 32'(wr_ready), 32'd1);
    commit();
    check_eq("sp_rd_valid", 32'(rd_valid), 32'd1);
    check_eq("sp_rd_data", 32'(rd_data), 32'hA);
    drive(1'b0, 4'h0, 1'b1);
    commit();

    // Fill with 0x1..0xF while the consumer is stalled.
    base_acc = n_acc;
    d = 1;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, DW'(d), 1'b0);
      a = wr_ready;
      commit();
      if (a && d < 15) d++;
    end
    check_eq("fill_accepted", 32'(n_acc - base_acc), 32'd9);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_level", 32'(level), 32'd9);
    check_eq("fill_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("fill_rd_valid", 32'(rd_valid), 32'd1);
    check_eq("fill_rd_data", 32'(rd_data), 32'h1);

    // Drain from full: one pop every two cycles.
    base_pop = n_pop;
    for (int i = 0; i < 40 && model_q.size() > 0; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      a = rd_valid;
      commit();
      if (a && (n_pop - base_pop) > 1) check_eq("drain_pop_gap", 32'(pop_gap), 32'd2);
    end
    check_eq("drain_pops", 32'(n_pop - base_pop), 32'd9);
    check_eq("drain_empty", 32'(empty), 32'd1);

    // Concurrent push and pop with random data.
    chk_issue = 1'b1; low_km1 = 1'b0; low_km2 = 1'b0; phase_cyc = 0;
    prev_rd_valid = rd_valid; prev_popped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, DW'($urandom), 1'b1);
      commit();
    end
    chk_issue = 1'b0;
    for (int i = 0; i < 40 && model_q.size() > 0; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      commit();
    end
    check_eq("conc_drained", 32'(model_q.size()), 32'd0);

    // Reset while a read is in flight with three words left in RAM.
    base_acc = n_acc;
    for (int i = 0; i < 20 && (n_acc - base_acc) < 5; i++) begin
      drive(1'b1, DW'(7 + n_acc - base_acc), 1'b0);
      commit();
    end
    check_eq("prerst_pushes", 32'(n_acc - base_acc), 32'd5);
    drive(1'b0, 4'h0, 1'b1);
    commit();
    check_eq("prerst_level", 32'(level), 32'd4);
    check_eq("prerst_rd_valid", 32'(rd_valid), 32'd0);
    rst_n = 1'b0;
    model_q.delete();
    #2;
    check_eq("midrst_level", 32'(level), 32'd0);
    check_eq("midrst_wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("postrst_level", 32'(level), 32'd0);
    check_eq("postrst_rd_valid", 32'(rd_valid), 32'd0);
    prev_rd_valid = 1'b0; prev_popped = 1'b0;
    base_acc = n_acc;
    base_pop = n_pop;
    for (int i = 0; i < 5 && (n_acc - base_acc) < 1; i++) begin
      drive(1'b1, 4'h5, 1'b0);
      commit();
    end
    check_eq("postrst_push", 32'(n_acc - base_acc), 32'd1);
    for (int i = 0; i < 10 && model_q.size() > 0; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      commit();
    end
    check_eq("postrst_pops", 32'(n_pop - base_pop), 32'd1);
    check_eq("postrst_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
